// File: rtl/spi_initiator.sv
// spi_initiator: SPI mode-0 initiator. One NBITS-wide request word is sent
// MSB-first on mosi per transfer. The word returned on miso is captured and
// offered on the response stream.
//
// Parameters
//   NBITS   : transfer width in bits (>= 2)
//   CLK_DIV : sclk half-period in clk cycles (>= 1)
//
// Ports
//   clk, reset              : system clock; asynchronous active-low reset
//   req_val/req_rdy/req_msg : request stream (word to transmit)
//   resp_val/resp_rdy/resp_msg : response stream (word captured from miso)
//   resp_parity             : XOR of resp_msg (only with SPI_INITIATOR_PARITY_EN)
//   cs, sclk, mosi, miso    : SPI bus (cs active-low, sclk idle low)
//
// Optional feature macro: SPI_INITIATOR_PARITY_EN adds resp_parity.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a request, req_rdy high
// SETUP    | cs low, first sclk low half-period, mosi = bit NBITS-1
// SHIFT_HI | sclk high; miso was sampled on entry
// SHIFT_LO | sclk low between bits; register shifted on entry
// HOLD     | cs hold time after the last sclk fall
// RESP     | cs high, response offered, waits for resp_rdy
// GAP      | minimum cs-high time before the next frame

module spi_initiator #(
  parameter int NBITS   = 24,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [NBITS-1:0] req_msg,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_msg,
  output logic             cs,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
`ifdef SPI_INITIATOR_PARITY_EN
  ,
  output logic             resp_parity
`endif
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(NBITS);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, RESP, GAP
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr;
  logic [BW-1:0]    bit_cnt;
  logic [NBITS-1:0] shreg;
  logic             miso_q;

  logic tc, last_bit;
  logic tmr_load, load_en, sample_en, shift_en, capture_en;

  assign tc       = (tmr == '0);
  assign last_bit = (bit_cnt == BW'(NBITS - 1));

  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    load_en    = 1'b0;
    sample_en  = 1'b0;
    shift_en   = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      IDLE: if (req_val) begin
        state_d  = SETUP;
        tmr_load = 1'b1;
        load_en  = 1'b1;
      end
      // SETUP doubles as the low half-period before the first rising edge.
      SETUP, SHIFT_LO: if (tc) begin
        state_d   = SHIFT_HI;
        tmr_load  = 1'b1;
        sample_en = 1'b1;
      end
      SHIFT_HI: if (tc) begin
        state_d  = last_bit ? HOLD : SHIFT_LO;
        tmr_load = 1'b1;
        shift_en = 1'b1;
      end
      HOLD: if (tc) begin
        state_d    = RESP;
        capture_en = 1'b1;
      end
      RESP: if (resp_rdy) begin
        state_d  = GAP;
        tmr_load = 1'b1;
      end
      GAP: if (tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmr     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (tmr_load)    tmr <= TW'(CLK_DIV - 1);
      else if (!tc)    tmr <= tmr - 1'b1;
      if (load_en)                    bit_cnt <= '0;
      else if (shift_en && !last_bit) bit_cnt <= bit_cnt + 1'b1;
      // miso is sampled as sclk rises and enters the register as sclk falls.
      if (sample_en) miso_q <= miso;
      if (load_en)       shreg <= req_msg;
      else if (shift_en) shreg <= {shreg[NBITS-2:0], miso_q};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_msg <= '0;
    end else if (capture_en) begin
      resp_msg <= shreg;
    end
  end

`ifdef SPI_INITIATOR_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_parity <= 1'b0;
    end else if (capture_en) begin
      resp_parity <= ^shreg;
    end
  end
`endif

  // Bus outputs decode the registered state so reset reaches the pins at once.
  assign req_rdy  = (state_q == IDLE);
  assign resp_val = (state_q == RESP);
  assign cs       = !(state_q == SETUP || state_q == SHIFT_HI ||
                      state_q == SHIFT_LO || state_q == HOLD);
  assign sclk     = (state_q == SHIFT_HI);
  assign mosi     = shreg[NBITS-1];

endmodule
